// File: rtl/vedic_mac_accumulator.sv
// rtl/vedic_mac_accumulator.sv - saturating frame accumulator for the vedic16b product stream
module vedic_mac_accumulator #(
  parameter int ACC_W   = 40,
  parameter int N_TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_terms,
  output logic             out_ovf
);

  typedef enum logic {ACC, OUT} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [7:0]       out_terms_q, out_terms_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W:0]   nsum;
  logic             sat;
  logic [ACC_W-1:0] sat_sum;
  logic             frame_end;
  logic             accept;

  // One extra carry bit detects overflow; a saturated acc stays all-ones since prod >= 0.
  assign nsum      = {1'b0, acc_q} + {{(ACC_W-31){1'b0}}, prod};
  assign sat       = nsum[ACC_W];
  assign sat_sum   = sat ? {ACC_W{1'b1}} : nsum[ACC_W-1:0];
  assign frame_end = (cnt_q == 8'(N_TERMS-1)) || in_last;
  assign in_ready  = (state_q == ACC) && !clr;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_terms_d = out_terms_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACC: begin
        if (clr) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (accept) begin
          if (frame_end) begin
            out_sum_d   = sat_sum;
            out_terms_d = cnt_q + 8'd1;
            out_ovf_d   = ovf_q | sat;
            out_valid_d = 1'b1;
            state_d     = OUT;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
          end else begin
            acc_d = sat_sum;
            cnt_d = cnt_q + 8'd1;
            ovf_d = ovf_q | sat;
          end
        end
      end
      OUT: begin
        // clr drops the pending result even when out_ready is high.
        if (clr || out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_terms_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_terms_q <= out_terms_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_terms = out_terms_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// tb/tb_vedic_mac_accumulator.sv - directed and random checks of vedic_mac_accumulator against a frame model
module tb_vedic_mac_accumulator;

  localparam int ACC_W   = 33;
  localparam int N_TERMS = 4;
  localparam longint unsigned SAT_MAX = (64'd1 << ACC_W) - 64'd1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      prod = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_terms;
  logic             out_ovf;

  vedic_mac_accumulator #(.ACC_W(ACC_W), .N_TERMS(N_TERMS)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .prod(prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_terms(out_terms), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: terms of the open frame kept as a list; result summed on frame close.
  longint unsigned m_terms[$];
  bit              m_busy = 1'b0;
  bit              m_ov   = 1'b0;
  longint unsigned m_os   = 0;
  int              m_ot   = 0;
  bit              m_oo   = 1'b0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic close_frame();
    longint unsigned s = 0;
    bit o = 1'b0;
    foreach (m_terms[i]) begin
      s = s + m_terms[i];
      if (s > SAT_MAX) begin
        s = SAT_MAX;
        o = 1'b1;
      end
    end
    m_os = s;
    m_ot = m_terms.size();
    m_oo = o;
    m_ov = 1'b1;
    m_busy = 1'b1;
    m_terms.delete();
  endtask

  task automatic drive(input bit v, input logic [31:0] p, input bit l,
                       input bit ordy, input bit c, input bit r);
    @(negedge clk);
    in_valid = v; prod = p; in_last = l; out_ready = ordy; clr = c; rst = r;
    if (r) begin
      m_terms.delete();
      m_busy = 0; m_ov = 0; m_os = 0; m_ot = 0; m_oo = 0;
    end else if (!m_busy) begin
      if (c) m_terms.delete();
      else if (v) begin
        m_terms.push_back(longint'(p));
        if (m_terms.size() == N_TERMS || l) close_frame();
      end
    end else if (c || ordy) begin
      m_ov = 1'b0;
      m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_sum",   out_sum,   m_os);
    chk("out_terms", out_terms, longint'(m_ot));
    chk("out_ovf",   out_ovf,   m_oo);
    chk("in_ready",  in_ready,  (!m_busy && !clr));
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 32'd0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic put(input logic [31:0] p, input bit l, input bit ordy);
    drive(1'b1, p, l, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    idle(1'b1);

    // Back-to-back frame 1..4
    put(1, 0, 1); put(2, 0, 1); put(3, 0, 1); put(4, 0, 1);
    chk("f1_valid", out_valid, 1);
    chk("f1_sum", out_sum, 10);
    chk("f1_terms", out_terms, 4);
    chk("f1_ovf", out_ovf, 0);
    chk("f1_in_ready_low", in_ready, 0);
    idle(1'b1);
    chk("f1_in_ready_back", in_ready, 1);
    chk("f1_handshake", out_valid, 0);

    // Backpressure
    put(1, 0, 0); put(2, 0, 0); put(3, 0, 0); put(4, 0, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk("bp_hold_sum", out_sum, 10);
      chk("bp_in_ready", in_ready, 0);
    end
    idle(1'b1);
    chk("bp_release", out_valid, 0);

    // Early end
    put(100, 0, 1); put(200, 1, 1);
    chk("early_sum", out_sum, 300);
    chk("early_terms", out_terms, 2);
    chk("early_ovf", out_ovf, 0);
    idle(1'b1);

    // Saturation, then a clean frame
    for (int i = 0; i < 4; i++) put(32'hFFFE_0001, 0, 1);
    chk("sat_sum", out_sum, 64'h1_FFFF_FFFF);
    chk("sat_terms", out_terms, 4);
    chk("sat_ovf", out_ovf, 1);
    idle(1'b1);
    for (int i = 0; i < 4; i++) put(5, 0, 1);
    chk("post_sat_sum", out_sum, 20);
    chk("post_sat_ovf", out_ovf, 0);
    idle(1'b1);

    // clr in ACC with coincident valid, then clr during OUT
    put(7, 0, 1); put(9, 0, 1);
    drive(1, 50, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) put(1, 0, 1);
    chk("clr_sum", out_sum, 4);
    chk("clr_terms", out_terms, 4);
    idle(1'b1);
    for (int i = 0; i < 4; i++) put(1, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    chk("clr_out_drop", out_valid, 0);

    // rst mid-frame and during OUT
    put(3, 0, 1); put(3, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    chk("rst_mid_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) put(2, 0, 0);
    chk("rst_mid_sum", out_sum, 8);
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_out_sum2", out_sum, 0);
    chk("rst_out_terms", out_terms, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 1000);
      drive($urandom_range(0, 9) < 7, p, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0,
            $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
